rr_arbiter_4: RTL and testbench



---
 rtl/rr_arbiter_4.sv | 124 ++++++++++++
 tb/tb_rr_arbiter_4.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_4
// Description : Four-requester round-robin arbiter with ownership hold and a
//               bounded-tenure preemption counter. The grant is a registered
//               one-hot vector decoded from a registered 2-bit owner index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8,   // max consecutive grant cycles while contended (1..255)
    parameter int CNT_W    = 8    // tenure counter width, 2**CNT_W > MAX_HOLD
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_last;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_gnt;
    logic [1:0]       r_gnt_idx;
    logic             r_gnt_valid;

    logic             w_found;
    logic [1:0]       w_winner;
    logic [1:0]       w_scan;
    logic [3:0]       w_others;
    logic             w_own;
    logic             w_tenure_full;

    // Priority search: first requester at or after last+1, wrapping 3 -> 0.
    // Scanning from the far end lets the nearest hit overwrite earlier ones.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last + 2'd1;
        w_scan   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_scan = r_last + 2'(k + 1);
            if (req[w_scan]) begin
                w_found  = 1'b1;
                w_winner = w_scan;
            end
        end
    end

    // Owner's own request, competing requests, and tenure limit status.
    always_comb begin
        w_own         = req[r_gnt_idx];
        w_others      = req & ~(4'b0001 << r_gnt_idx);
        w_tenure_full = (r_cnt == c_cnt_max);
    end

    // Arbitration state machine; every output is registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_last      <= 2'd3;
            r_cnt       <= '0;
            r_gnt       <= 4'b0000;
            r_gnt_idx   <= 2'd0;
            r_gnt_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state     <= S_GRANT;
                        r_gnt       <= 4'b0001 << w_winner;
                        r_gnt_idx   <= w_winner;
                        r_gnt_valid <= 1'b1;
                        r_last      <= w_winner;
                        r_cnt       <= '0;
                    end
                end
                S_GRANT: begin
                    if (!w_own) begin
                        if (w_found) begin
                            // Owner released while others wait: hand over with no bubble.
                            r_gnt     <= 4'b0001 << w_winner;
                            r_gnt_idx <= w_winner;
                            r_last    <= w_winner;
                            r_cnt     <= '0;
                        end else begin
                            // Nobody wants the slot; gnt_idx and last keep the old owner.
                            r_state     <= S_IDLE;
                            r_gnt       <= 4'b0000;
                            r_gnt_valid <= 1'b0;
                        end
                    end else if (w_tenure_full && (|w_others)) begin
                        // Tenure exhausted with a competitor: search starts past the
                        // owner, so the owner is never re-selected here.
                        r_gnt     <= 4'b0001 << w_winner;
                        r_gnt_idx <= w_winner;
                        r_last    <= w_winner;
                        r_cnt     <= '0;
                    end else if (!w_tenure_full) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_gnt       <= 4'b0000;
                    r_gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_4
// Description : Self-checking bench for rr_arbiter_4 with a behavioural
//               reference model (owner, last winner, cycles held).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_4;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         m_valid;
    int         m_owner;
    int         m_last;
    int         m_ten;     // cycles the current owner has held the grant
    logic [3:0] m_gnt;

    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task model_reset();
        m_valid = 0; m_owner = 0; m_last = 3; m_ten = 0; m_gnt = 4'b0000;
    endtask

    task model_take(input logic [3:0] r);
        int found;
        found = 0;
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (found == 0 && r[c]) begin
                found = 1; m_owner = c; m_last = c; m_valid = 1; m_ten = 1;
            end
        end
    endtask

    task model_step(input logic [3:0] r);
        int others;
        others = 0;
        for (int k = 0; k < 4; k++)
            if (r[k] && !(m_valid != 0 && k == m_owner)) others = 1;
        if (m_valid == 0) begin
            if (r != 4'b0000) model_take(r);
        end else if (!r[m_owner]) begin
            if (r != 4'b0000) model_take(r);
            else m_valid = 0;
        end else if (m_ten >= MAX_HOLD && others != 0) begin
            model_take(r);
        end else begin
            m_ten = m_ten + 1;
        end
        m_gnt = (m_valid != 0) ? 4'(1 << m_owner) : 4'b0000;
    endtask

    // Drive req between edges, take one edge, sample 1 ns after it.
    task tick(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task do_reset();
        req = 4'b0000;
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task test_reset();
        do_reset();
        n_checks++;
        if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got gnt=%b idx=%0d valid=%b, want 0000/0/0", gnt, gnt_idx, gnt_valid);
        end
        tick(4'b0100);
        n_checks++;
        if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_req: got gnt=%b idx=%0d valid=%b, want 0100/2/1", gnt, gnt_idx, gnt_valid);
        end
        tick(4'b0000);
        n_checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL release_idle: got gnt=%b idx=%0d valid=%b, want 0000/2/0", gnt, gnt_idx, gnt_valid);
        end
    endtask

    task test_round_robin();
        logic [3:0] exp_seq [5];
        logic [3:0] r;
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
        do_reset();
        r = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick(r);
            n_checks++;
            if (gnt !== exp_seq[i] || gnt !== m_gnt || gnt_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: got gnt=%b valid=%b, want %b/1", i, gnt, gnt_valid, exp_seq[i]);
            end
            r = 4'b1111 & ~exp_seq[i];   // owner drops, everyone else re-asserts
        end
    endtask

    task test_preemption();
        logic [3:0] exp;
        do_reset();
        for (int i = 0; i < 4 * MAX_HOLD; i++) begin
            tick(4'b0011);
            exp = (((i / MAX_HOLD) % 2) == 0) ? 4'b0001 : 4'b0010;
            n_checks++;
            if (gnt !== exp || gnt !== m_gnt) begin
                n_fail++;
                $display("FAIL preempt[%0d]: got gnt=%b, want %b", i, gnt, exp);
            end
        end
    endtask

    task test_sole_owner();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick(4'b1000);
            if (gnt !== 4'b1000 || gnt_idx !== 2'd3) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sole_owner: %0d cycles with gnt != 1000 (last gnt=%b), want 0", bad, gnt);
        end
        tick(4'b1001);
        n_checks++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL sole_owner_preempt: got gnt=%b idx=%0d, want 0001/0", gnt, gnt_idx);
        end
    endtask

    task test_wrap();
        do_reset();
        tick(4'b1000);
        tick(4'b0000);
        tick(4'b1001);
        n_checks++;
        if (gnt !== 4'b0001 || gnt !== m_gnt) begin
            n_fail++;
            $display("FAIL wrap_to_0: got gnt=%b, want 0001", gnt);
        end
        tick(4'b1000);
        n_checks++;
        if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
            n_fail++;
            $display("FAIL wrap_back_3: got gnt=%b idx=%0d, want 1000/3", gnt, gnt_idx);
        end
    endtask

    task test_async_reset();
        do_reset();
        tick(4'b0010);
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL async_pre: got gnt=%b, want 0010", gnt);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear: got gnt=%b valid=%b, want 0000/0", gnt, gnt_valid);
        end
        #1 reset_n = 1'b1;
        model_reset();
        tick(4'b1010);
        n_checks++;
        if (gnt !== 4'b0010 || gnt_idx !== 2'd1 || gnt !== m_gnt) begin
            n_fail++;
            $display("FAIL async_restart: got gnt=%b idx=%0d, want 0010/1", gnt, gnt_idx);
        end
    endtask

    task test_random();
        logic [3:0] r;
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (r[b]) r[b] = ($urandom_range(0, 99) < 80);
                else      r[b] = ($urandom_range(0, 99) < 30);
            end
            tick(r);
            n_checks++;
            if ({gnt_valid, gnt} !== {(m_valid != 0), m_gnt} || (m_valid != 0 && gnt_idx !== 2'(m_owner))) begin
                n_fail++;
                $display("FAIL random[%0d] req=%b: got gnt=%b idx=%0d valid=%b, want %b/%0d/%0d",
                         i, r, gnt, gnt_idx, gnt_valid, m_gnt, m_owner, m_valid);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_round_robin();
        test_preemption();
        test_sole_owner();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
